// File: rtl/dmem_lsu_pkg.sv
// Shared types and widths for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_ISSUE  = 3'd1,
    LD_CAPT   = 3'd2,
    RMW_ISSUE = 3'd3,
    RMW_MERGE = 3'd4,
    ST_WRITE  = 3'd5
  } state_t;

  // Request fields still needed after the accepting edge
  typedef struct packed {
    logic              is_byte;
    logic              is_signed;
    logic              lane_hi;
    logic [LANE_W-1:0] wbyte;
  } req_t;

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane extraction with sign/zero extension for loads, and byte merge for
// read-modify-write stores.
module dmem_lane_merge
  import dmem_lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic              lane_hi,
  input  logic              is_byte,
  input  logic              is_signed,
  input  logic [LANE_W-1:0] wbyte,
  output logic [DATA_W-1:0] load_c,
  output logic [DATA_W-1:0] merge_c
);

  logic [LANE_W-1:0] lane;

  always_comb begin
    lane    = lane_hi ? word[DATA_W-1:LANE_W] : word[LANE_W-1:0];
    load_c  = word;
    if (is_byte) begin
      load_c = {{LANE_W{is_signed & lane[LANE_W-1]}}, lane};
    end
    merge_c = lane_hi ? {wbyte, word[LANE_W-1:0]} : {word[DATA_W-1:LANE_W], wbyte};
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU MEM stage and a 1024x16 single-port data RAM.
// Byte stores go through read-modify-write because the RAM has no byte enables.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  output logic              mem_reset,
  output logic [MEM_AW-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state;
  req_t              req;
  logic [MEM_AW-1:0] idx;
  logic              accept_c;
  logic              err_c;
  logic [MEM_AW-1:0] idx_c;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] merge_c;

  assign accept_c  = req_valid && req_ready;
  assign idx_c     = MEM_AW'((req_addr - BASE_ADDR) >> 1);
  assign err_c     = (req_addr[ADDR_W-1:MEM_AW+1] != BASE_ADDR[ADDR_W-1:MEM_AW+1]) ||
                     (!req_byte && req_addr[0]);
  assign mem_oce   = mem_ce;
  assign mem_reset = !rst_n;

  dmem_lane_merge u_lane_merge (
    .word      (mem_dout),
    .lane_hi   (req.lane_hi),
    .is_byte   (req.is_byte),
    .is_signed (req.is_signed),
    .wbyte     (req.wbyte),
    .load_c    (load_c),
    .merge_c   (merge_c)
  );

  // Controller; RAM strobes are registered so they line up with the issue/write states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req       <= '0;
      idx       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_ce    <= 1'b0;
      mem_wre   <= 1'b0;
      mem_ad    <= '0;
      mem_din   <= '0;
    end else begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_ce    <= 1'b0;
      mem_wre   <= 1'b0;
      mem_ad    <= '0;
      mem_din   <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept_c) begin
            req <= '{is_byte: req_byte, is_signed: req_signed,
                     lane_hi: req_addr[0], wbyte: req_wdata[LANE_W-1:0]};
            idx <= idx_c;
            if (err_c) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              req_ready <= 1'b0;
              mem_ce    <= 1'b1;
              mem_ad    <= idx_c;
              if (!req_we) begin
                state <= LD_ISSUE;
              end else if (req_byte) begin
                state <= RMW_ISSUE;
              end else begin
                state   <= ST_WRITE;
                mem_wre <= 1'b1;
                mem_din <= req_wdata;
              end
            end
          end
        end
        LD_ISSUE:  state <= LD_CAPT;
        LD_CAPT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_c;
        end
        RMW_ISSUE: state <= RMW_MERGE;
        RMW_MERGE: begin
          state   <= ST_WRITE;
          mem_ce  <= 1'b1;
          mem_wre <= 1'b1;
          mem_ad  <= idx;
          mem_din <= merge_c;
        end
        ST_WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed plus randomized bench for dmem_lsu against a transaction-level model
// of the RAM window, with a behavioural bypass-mode RAM attached to the DUT.
module tb_dmem_lsu;

  localparam int unsigned BASE = 32'h0000;
  localparam int unsigned WIN  = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_ce;
  logic        mem_oce;
  logic        mem_wre;
  logic        mem_reset;
  logic [9:0]  mem_ad;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;

  logic [15:0] ram     [1024] = '{default: '0};
  logic [15:0] ref_mem [1024] = '{default: '0};

  int n_checks = 0;
  int n_fail   = 0;
  bit check_gap = 0;

  dmem_lsu #(.ADDR_W(16), .MEM_AW(10), .BASE_ADDR(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_ce     (mem_ce),
    .mem_oce    (mem_oce),
    .mem_wre    (mem_wre),
    .mem_reset  (mem_reset),
    .mem_ad     (mem_ad),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM, output in bypass mode: read data appears after the read edge
  always @(posedge clk) begin
    if (mem_reset) begin
      mem_dout <= '0;
    end else if (mem_ce) begin
      if (mem_wre) ram[mem_ad] <= mem_din;
      else if (mem_oce) mem_dout <= ram[mem_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result of one transaction from the addressing/extension rules
  function automatic void model(input logic we, input logic bt, input logic sg,
                                input logic [15:0] addr, input logic [15:0] wd,
                                output logic [15:0] rd, output logic er, output int lat);
    int unsigned a, off, idx, lo, hi, b;
    a  = 32'(addr);
    rd = '0;
    er = (a < BASE) || (a >= BASE + WIN) || (!bt && (a % 2 == 1));
    lat = 1;
    if (er) return;
    off = a - BASE;
    idx = off / 2;
    lo  = 32'(ref_mem[idx]) % 256;
    hi  = 32'(ref_mem[idx]) / 256;
    if (!we) begin
      lat = 3;
      if (!bt) begin
        rd = ref_mem[idx];
      end else begin
        b  = (off % 2 == 1) ? hi : lo;
        rd = 16'(b);
        if (sg && b >= 128) rd = 16'(b + 32'hFF00);
      end
    end else if (!bt) begin
      lat = 2;
      ref_mem[idx] = wd;
    end else begin
      lat = 4;
      b = 32'(wd) % 256;
      if (off % 2 == 1) hi = b;
      else lo = b;
      ref_mem[idx] = 16'(hi * 256 + lo);
    end
  endfunction

  // Present a request from the current cycle; return on the response cycle
  task automatic do_req(input logic we, input logic bt, input logic sg,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic er, output int lat,
                        output logic ce_seen, output int wait_n);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    ce_seen = 1'b0;
    while (!rsp_valid && lat < 10) begin
      ce_seen |= mem_ce;
      @(posedge clk); #1;
      lat++;
    end
    ce_seen |= mem_ce;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic txn(input string tag, input logic we, input logic bt, input logic sg,
                     input logic [15:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic er);
    logic [15:0] erd;
    logic        eer;
    int          elat, lat, wait_n;
    logic        ce_seen;
    model(we, bt, sg, addr, wd, erd, eer, elat);
    do_req(we, bt, sg, addr, wd, rd, er, lat, ce_seen, wait_n);
    chk({tag, "/lat"}, 32'(lat), 32'(elat));
    chk({tag, "/rdata"}, 32'(rd), 32'(erd));
    chk({tag, "/err"}, 32'(er), 32'(eer));
    if (eer) chk({tag, "/ce"}, 32'(ce_seen), 32'd0);
    if (check_gap) chk({tag, "/gap"}, 32'(wait_n), 32'd0);
    check_gap = 1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd, addr;
    logic        er, we, bt, sg;
    int unsigned widx;

    #1 rst_n = 1'b0;
    #1;
    chk("rst/ready", 32'(req_ready), 32'd0);
    chk("rst/rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("rst/mem_ctl", 32'({mem_ce, mem_oce, mem_wre}), 32'd0);
    chk("rst/mem_bus", 32'({mem_ad, mem_din}), 32'd0);
    chk("rst/mem_reset", 32'(mem_reset), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Word store then word load
    txn("t1_st", 1, 0, 0, 16'h0010, 16'hBEEF, rd, er);
    chk("t1_ram8", 32'(ram[8]), 32'h0000BEEF);
    txn("t1_ld", 0, 0, 0, 16'h0010, 16'h0000, rd, er);
    chk("t1_ld_const", 32'(rd), 32'h0000BEEF);

    // Byte store into the high lane, then signed/unsigned byte loads
    txn("t2_st", 1, 1, 0, 16'h0011, 16'h1280, rd, er);
    chk("t2_ram8", 32'(ram[8]), 32'h000080EF);
    txn("t2_lds", 0, 1, 1, 16'h0011, 16'h0000, rd, er);
    chk("t2_lds_const", 32'(rd), 32'h0000FF80);
    txn("t2_ldu", 0, 1, 0, 16'h0011, 16'h0000, rd, er);
    chk("t2_ldu_const", 32'(rd), 32'h00000080);
    txn("t2_ldlo", 0, 1, 1, 16'h0010, 16'h0000, rd, er);
    chk("t2_ldlo_const", 32'(rd), 32'h0000FFEF);

    // Misaligned and out-of-window accesses
    txn("t3_mis", 0, 0, 0, 16'h0003, 16'h0000, rd, er);
    chk("t3_mis_err", 32'(er), 32'd1);
    txn("t3_oow", 0, 0, 0, 16'h0800, 16'h0000, rd, er);
    chk("t3_oow_err", 32'(er), 32'd1);
    txn("t3_oow_st", 1, 1, 0, 16'hFFFF, 16'h00AA, rd, er);

    // Back-to-back: store issued in the response cycle of a load
    txn("t4_ld", 0, 0, 0, 16'h0010, 16'h0000, rd, er);
    txn("t4_st", 1, 0, 0, 16'h0020, 16'h5A5A, rd, er);
    chk("t4_ram16", 32'(ram[16]), 32'h00005A5A);

    // Top of the window: upper lane of word 1023
    txn("t5_init", 1, 0, 0, 16'h07FE, 16'h1234, rd, er);
    txn("t5_st", 1, 1, 0, 16'h07FF, 16'h00C3, rd, er);
    txn("t5_ld", 0, 0, 0, 16'h07FE, 16'h0000, rd, er);
    chk("t5_ld_const", 32'(rd), 32'h0000C334);
    chk("t5_ram1023", 32'(ram[1023]), 32'h0000C334);

    // Reset while the write strobe is active
    txn("t6_pre", 1, 0, 0, 16'h0040, 16'h1234, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0040; req_wdata = 16'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t6_write_active", 32'({mem_ce, mem_wre}), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_ce_drop", 32'(mem_ce), 32'd0);
    chk("t6_ready_rst", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    chk("t6_ram32", 32'(ram[32]), 32'h00001234);
    @(posedge clk); #1;
    chk("t6_ready_after", 32'(req_ready), 32'd1);
    chk("t6_no_rsp_after", 32'(rsp_valid), 32'd0);

    // Randomized traffic, mostly inside the window
    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom);
      bt = 1'($urandom);
      sg = 1'($urandom);
      if ($urandom_range(0, 9) < 9) addr = 16'($urandom_range(0, WIN - 1));
      else addr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #0;
      txn("rnd", we, bt, sg, addr, 16'($urandom), rd, er);
      if (32'(addr) < WIN) begin
        widx = 32'(addr) / 2;
        chk("rnd_ram", 32'(ram[widx]), 32'(ref_mem[widx]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
